// File: rtl/operand_frame_loader.sv
// Byte-stream to six-operand frame loader: assembles bytes into a..f with a
// working set that fills while the previous frame waits at the output.
module operand_frame_loader #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] f,
    output logic             ops_valid,
    input  logic             ops_ready,
    output logic [7:0]       frame_cnt,
    output logic             busy
);

    typedef enum logic {FILL, FULL} state_t;

    state_t           state_reg, state_next;
    logic [2:0]       idx_reg, idx_next;
    logic             ops_valid_reg, ops_valid_next;
    logic [7:0]       frame_cnt_reg, frame_cnt_next;
    logic [WIDTH-1:0] w_reg  [6];
    logic [WIDTH-1:0] op_reg [6];

    logic accept, slot_free, complete, load_direct, load_stalled;

    always_comb begin
        in_ready     = (state_reg == FILL) && !flush && !rst;
        accept       = in_valid && in_ready;
        slot_free    = !ops_valid_reg || ops_ready;
        complete     = accept && (idx_reg == 3'd5);
        load_direct  = complete && slot_free;
        // FULL implies the output slot is occupied, so ops_valid_reg is always set here
        load_stalled = (state_reg == FULL) && ops_valid_reg && ops_ready && !flush;
    end

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        ops_valid_next = ops_valid_reg;
        frame_cnt_next = frame_cnt_reg;
        if (flush) begin
            state_next     = FILL;
            idx_next       = 3'd0;
            ops_valid_next = 1'b0;
        end else begin
            if (ops_valid_reg && ops_ready)
                ops_valid_next = 1'b0;
            if (load_direct || load_stalled) begin
                state_next     = FILL;
                idx_next       = 3'd0;
                ops_valid_next = 1'b1;
                frame_cnt_next = frame_cnt_reg + 8'd1;
            end else if (complete) begin
                state_next = FULL;
            end else if (accept) begin
                idx_next = idx_reg + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= FILL;
            idx_reg       <= 3'd0;
            ops_valid_reg <= 1'b0;
            frame_cnt_reg <= 8'd0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            ops_valid_reg <= ops_valid_next;
            frame_cnt_reg <= frame_cnt_next;
        end
    end

    for (genvar gi = 0; gi < 6; gi++) begin : g_slot
        always_ff @(posedge clk) begin
            if (rst || flush)
                w_reg[gi] <= '0;
            else if (accept && idx_reg == 3'(gi))
                w_reg[gi] <= in_data;
        end

        // On a direct completion the last operand bypasses the working set
        always_ff @(posedge clk) begin
            if (rst)
                op_reg[gi] <= '0;
            else if (load_direct)
                op_reg[gi] <= (gi == 5) ? in_data : w_reg[gi];
            else if (load_stalled)
                op_reg[gi] <= w_reg[gi];
        end
    end

    assign a         = op_reg[0];
    assign b         = op_reg[1];
    assign c         = op_reg[2];
    assign d         = op_reg[3];
    assign e         = op_reg[4];
    assign f         = op_reg[5];
    assign ops_valid = ops_valid_reg;
    assign frame_cnt = frame_cnt_reg;
    assign busy      = (state_reg == FULL) || (idx_reg != 3'd0);

endmodule

// File: tb/tb_operand_frame_loader.sv
// Bench for operand_frame_loader: directed scenarios plus random traffic,
// all checked every cycle against a queue-based frame model.
module tb_operand_frame_loader;

    logic       clk = 1'b0;
    logic       rst, flush, in_valid, in_ready, ops_valid, ops_ready, busy;
    logic [7:0] in_data, a, b, c, d, e, f, frame_cnt;

    always #5 clk = ~clk;

    operand_frame_loader #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
        .ops_valid(ops_valid), .ops_ready(ops_ready),
        .frame_cnt(frame_cnt), .busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: bytes of the partial frame, an optional stalled frame, the output frame
    logic [7:0] q[$];
    logic [7:0] m_stall[6];
    logic       m_has_stall = 1'b0;
    logic [7:0] m_out[6];
    logic       m_valid = 1'b0;
    logic [7:0] m_cnt = 8'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic model_ready(input logic fl, input logic r);
        return !m_has_stall && !fl && !r;
    endfunction

    task automatic model_edge(input logic v, input logic [7:0] dat, input logic rdy,
                              input logic fl, input logic r);
        logic rd_now, loaded, fired;
        rd_now = model_ready(fl, r);
        loaded = 1'b0;
        fired  = m_valid && rdy;
        if (r) begin
            q.delete();
            m_has_stall = 1'b0;
            for (int i = 0; i < 6; i++) m_out[i] = 8'd0;
            m_valid = 1'b0;
            m_cnt   = 8'd0;
        end else if (fl) begin
            q.delete();
            m_has_stall = 1'b0;
            m_valid     = 1'b0;
        end else begin
            if (m_has_stall && fired) begin
                m_out       = m_stall;
                m_has_stall = 1'b0;
                loaded      = 1'b1;
            end else if (v && rd_now) begin
                q.push_back(dat);
                if (q.size() == 6) begin
                    if (!m_valid || rdy) begin
                        for (int i = 0; i < 6; i++) m_out[i] = q[i];
                        loaded = 1'b1;
                    end else begin
                        for (int i = 0; i < 6; i++) m_stall[i] = q[i];
                        m_has_stall = 1'b1;
                    end
                    q.delete();
                end
            end
            if (loaded) begin
                m_valid = 1'b1;
                m_cnt   = m_cnt + 8'd1;
                $display("[TB] frame %0d -> %h %h %h %h %h %h", m_cnt,
                         m_out[0], m_out[1], m_out[2], m_out[3], m_out[4], m_out[5]);
            end else if (fired) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        check("ops_valid", ops_valid, m_valid);
        check("a", a, m_out[0]);
        check("b", b, m_out[1]);
        check("c", c, m_out[2]);
        check("d", d, m_out[3]);
        check("e", e, m_out[4]);
        check("f", f, m_out[5]);
        check("frame_cnt", frame_cnt, m_cnt);
        check("busy", busy, m_has_stall || (q.size() != 0));
    endtask

    // One clock: drive at the falling edge, model the rising edge, compare at the next fall
    task automatic cycle(input logic v, input logic [7:0] dat, input logic rdy,
                         input logic fl, input logic r);
        in_valid  = v;
        in_data   = dat;
        ops_ready = rdy;
        flush     = fl;
        rst       = r;
        #1;
        check("in_ready", in_ready, model_ready(fl, r));
        @(posedge clk);
        model_edge(v, dat, rdy, fl, r);
        @(negedge clk);
        compare_all();
    endtask

    task automatic send(input logic [7:0] dat, input logic rdy);
        cycle(1'b1, dat, rdy, 1'b0, 1'b0);
    endtask

    logic [7:0] basic[6];
    logic [7:0] cnt0;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'd0; ops_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin m_out[i] = 8'd0; m_stall[i] = 8'd0; end
        @(negedge clk);

        // Reset state
        cycle(0, 0, 1, 0, 1);
        cycle(0, 0, 1, 0, 1);
        check("rst_valid", ops_valid, 0);
        check("rst_cnt", frame_cnt, 0);
        check("rst_a", a, 0);

        // Basic frame
        basic[0] = 8'd12; basic[1] = 8'd2; basic[2] = 8'hA9;
        basic[3] = 8'd8;  basic[4] = 8'hB4; basic[5] = 8'd2;
        for (int i = 0; i < 6; i++) send(basic[i], 1);
        check("basic_a", a, 12);
        check("basic_c", c, 8'hA9);
        check("basic_e", e, 8'hB4);
        check("basic_f", f, 2);
        check("basic_valid", ops_valid, 1);
        check("basic_cnt", frame_cnt, 1);
        cycle(0, 0, 1, 0, 0);
        check("basic_one_cycle", ops_valid, 0);

        // Back-pressure
        cycle(0, 0, 0, 0, 1);
        for (int i = 1; i <= 12; i++) send(8'(i), 0);
        check("bp_a_held", a, 1);
        check("bp_f_held", f, 6);
        check("bp_in_ready", in_ready, 0);
        check("bp_busy", busy, 1);
        cycle(0, 0, 1, 0, 0);
        check("bp_a_new", a, 7);
        check("bp_f_new", f, 12);
        check("bp_valid", ops_valid, 1);
        check("bp_cnt", frame_cnt, 2);
        check("bp_ready_again", in_ready, 1);
        cycle(0, 0, 1, 0, 0);

        // Gapped input
        cnt0 = frame_cnt;
        for (int i = 0; i < 6; i++) begin
            send(8'h10 + 8'(i), 1);
            if (i < 5) cycle(0, 8'hEE, 1, 0, 0);
        end
        check("gap_a", a, 8'h10);
        check("gap_d", d, 8'h13);
        check("gap_f", f, 8'h15);
        check("gap_cnt", frame_cnt, cnt0 + 8'd1);
        cycle(0, 0, 1, 0, 0);

        // Flush mid-frame
        cnt0 = frame_cnt;
        for (int i = 0; i < 3; i++) send(8'h50 + 8'(i), 1);
        in_valid = 1'b1; flush = 1'b1; #1;
        check("flush_in_ready", in_ready, 0);
        cycle(1, 8'h77, 1, 1, 0);
        for (int i = 0; i < 6; i++) send(8'h21 + 8'(i), 1);
        check("flush_a", a, 8'h21);
        check("flush_f", f, 8'h26);
        check("flush_cnt", frame_cnt, cnt0 + 8'd1);
        cycle(0, 0, 1, 0, 0);

        // Reset mid-operation
        for (int i = 0; i < 10; i++) send(8'h60 + 8'(i), 0);
        check("mid_pending", ops_valid, 1);
        cycle(0, 0, 0, 0, 1);
        check("mid_valid", ops_valid, 0);
        check("mid_a", a, 0);
        check("mid_cnt", frame_cnt, 0);
        check("mid_busy", busy, 0);
        for (int i = 0; i < 6; i++) send(8'h80 + 8'(i), 1);
        check("mid_clean_a", a, 8'h80);
        check("mid_clean_f", f, 8'h85);
        check("mid_clean_cnt", frame_cnt, 1);

        // Counter wrap
        cycle(0, 0, 1, 0, 1);
        for (int k = 1; k <= 256; k++) begin
            for (int i = 0; i < 6; i++) send(8'($urandom), 1);
            if (k == 255) check("wrap_255", frame_cnt, 255);
            if (k == 256) check("wrap_0", frame_cnt, 0);
        end

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 6,
                  $urandom_range(0, 59) == 0, $urandom_range(0, 299) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
